// File: rtl/snake_pkg.sv
// Shared types and sizes for the snake game datapath (score counter and display).
package snake_pkg;
  localparam int SCORE_W       = 8;
  localparam int LEVEL_W       = 3;
  localparam int MAX_SCORE_DEF = 99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;
endpackage

// File: rtl/score_counter_rise_detect.sv
// Registered rising-edge detector; rise_o is high for the cycle in which d_i goes 0->1.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/score_counter.sv
// Game score counter: counts eat edges while running, saturates, derives speed level.
// Optional session high score / new-record tracking under SCORE_HIGH_SCORE_EN.
module score_counter
  import snake_pkg::*;
#(
  parameter int MAX_SCORE       = MAX_SCORE_DEF,
  parameter int POINTS_PER_FOOD = 1,
  parameter int LEVEL_STEP      = 10,
  parameter int MAX_LEVEL       = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_start,
  input  logic               game_over,
  input  logic               eat,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level,
  output logic               running,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record
);
  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d, step_q, step_d;
  logic [SCORE_W-1:0] sum, add, step_sum;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               eat_rise, count, clear;

  rise_detect u_eat_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (eat),
    .rise_o (eat_rise)
  );

  // Only the points that actually land in the score feed the level step counter.
  assign sum      = score_q + SCORE_W'(POINTS_PER_FOOD);
  assign add      = (sum > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) - score_q
                                                 : SCORE_W'(POINTS_PER_FOOD);
  assign step_sum = step_q + add;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    level_d = level_q;
    step_d  = step_q;
    clear   = 1'b0;
    count   = 1'b0;
    if (game_start) begin
      state_d = RUN;
      clear   = 1'b1;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN: begin
          if (game_over)     state_d = OVER;
          else if (eat_rise) count   = 1'b1;
        end
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
    if (clear) begin
      score_d = '0;
      level_d = '0;
      step_d  = '0;
    end else if (count) begin
      score_d = score_q + add;
      if (step_sum >= SCORE_W'(LEVEL_STEP)) begin
        step_d = step_sum - SCORE_W'(LEVEL_STEP);
        if (level_q < LEVEL_W'(MAX_LEVEL)) level_d = level_q + 1'b1;
      end else begin
        step_d = step_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      score_q <= '0;
      level_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      level_q <= level_d;
      step_q  <= step_d;
    end
  end

  assign score   = score_q;
  assign level   = level_q;
  assign running = (state_q == RUN);

`ifdef SCORE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;
  logic               rec_q;

  // high_q survives game_start; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_q <= '0;
      rec_q  <= 1'b0;
    end else if (clear) begin
      rec_q  <= 1'b0;
    end else if (count && (score_d > high_q)) begin
      high_q <= score_d;
      rec_q  <= 1'b1;
    end
  end

  assign high_score = high_q;
  assign new_record = rec_q;
`else
  assign high_score = '0;
  assign new_record = 1'b0;
`endif
endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter with a cycle-level reference model and per-cycle compare.
module tb_score_counter;
  localparam int P    = 1;
  localparam int MAXS = 99;
  localparam int STEP = 10;
  localparam int MAXL = 7;
`ifdef SCORE_HIGH_SCORE_EN
  localparam int HS = 1;
`else
  localparam int HS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_start = 1'b0;
  logic       game_over = 1'b0;
  logic       eat = 1'b0;
  logic [7:0] score, high_score;
  logic [2:0] level;
  logic       running, new_record;

  int vectors = 0;
  int errors  = 0;

  // Reference model: state 0=idle 1=run 2=over; level derived from score by division.
  int m_state = 0;
  int m_score = 0;
  int m_high  = 0;
  int m_rec   = 0;
  int m_eat_prev = 0;

  score_counter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_start (game_start),
    .game_over  (game_over),
    .eat        (eat),
    .score      (score),
    .level      (level),
    .running    (running),
    .high_score (high_score),
    .new_record (new_record)
  );

  always #5 clk = ~clk;

  function automatic int sat_add(input int s);
    return (s + P > MAXS) ? MAXS : s + P;
  endfunction

  function automatic int exp_level(input int s);
    return (s / STEP > MAXL) ? MAXL : s / STEP;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state    <= 0;
      m_score    <= 0;
      m_high     <= 0;
      m_rec      <= 0;
      m_eat_prev <= 0;
    end else begin
      m_eat_prev <= int'(eat);
      if (game_start) begin
        m_state <= 1;
        m_score <= 0;
        m_rec   <= 0;
      end else if (m_state == 1 && game_over) begin
        m_state <= 2;
      end else if (m_state == 1 && eat && m_eat_prev == 0) begin
        m_score <= sat_add(m_score);
        if (HS != 0 && sat_add(m_score) > m_high) begin
          m_high <= sat_add(m_score);
          m_rec  <= 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("cyc_score", int'(score), m_score);
      chk("cyc_level", int'(level), exp_level(m_score));
      chk("cyc_running", int'(running), (m_state == 1) ? 1 : 0);
      chk("cyc_high", int'(high_score), m_high);
      chk("cyc_record", int'(new_record), m_rec);
    end
  end

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      eat = 1'b1;
      repeat (hi) @(negedge clk);
      eat = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic start_pulse();
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic over_pulse();
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("rst_score", int'(score), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_high", int'(high_score), 0);
    chk("rst_record", int'(new_record), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    pulses(2, 1, 1);
    chk("idle_eat_ignored", int'(score), 0);

    start_pulse();
    chk("start_running", int'(running), 1);
    pulses(3, 5, 2);
    chk("three_long_eats", int'(score), 3);

    eat = 1'b1;
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    eat = 1'b0;
    @(negedge clk);
    chk("over_eat_same_cycle", int'(score), 3);
    chk("over_state", int'(running), 0);
    pulses(2, 1, 1);
    over_pulse();
    chk("over_eat_ignored", int'(score), 3);

    start_pulse();
    pulses(105, 1, 1);
    chk("saturate_score", int'(score), 99);
    chk("saturate_level", int'(level), 7);
    pulses(1, 1, 1);
    chk("saturate_hold", int'(score), 99);

    game_start = 1'b1;
    game_over  = 1'b1;
    eat        = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    game_over  = 1'b0;
    eat        = 1'b0;
    @(negedge clk);
    chk("start_wins_running", int'(running), 1);
    chk("start_wins_score", int'(score), 0);

    pulses(57, 1, 1);
    chk("reach_57", int'(score), 57);
    chk("level_at_57", int'(level), 5);
    eat = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_score", int'(score), 0);
    chk("async_level", int'(level), 0);
    chk("async_running", int'(running), 0);
    chk("async_high", int'(high_score), 0);
    chk("async_record", int'(new_record), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_pulse();
    repeat (3) @(negedge clk);
    chk("held_eat_no_count", int'(score), 0);
    eat = 1'b0;
    @(negedge clk);
    pulses(1, 1, 1);
    chk("fresh_edge_counts", int'(score), 1);

    pulses(11, 1, 1);
    chk("reach_12", int'(score), 12);
    chk("level_at_12", int'(level), 1);
    over_pulse();
    start_pulse();
    chk("restart_score", int'(score), 0);
    chk("restart_level", int'(level), 0);
    chk("restart_running", int'(running), 1);
    chk("restart_high", int'(high_score), HS * 12);
    chk("restart_record", int'(new_record), 0);
    pulses(12, 1, 1);
    chk("tie_no_record", int'(new_record), 0);
    pulses(1, 1, 1);
    chk("score_13", int'(score), 13);
    chk("record_set", int'(new_record), HS);
    chk("high_13", int'(high_score), HS * 13);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
